axi4s_packet_limiter: RTL and testbench

- Ingress-side packet policer that sits directly upstream of the packet gate.
- Enforces a beat-count window on each packet. Overlong packets are truncated with a forced tlast, and their remainder is discarded. Runt packets are passed through but flagged.
- Drives o_terror together with the final beat. This is the error input the packet gate consumes to drop bad packets.
- Flat AXI4-Stream ports; tdata/tuser/tkeep are packed into one WIDTH vector by the caller.

---
 rtl/axi4s_packet_limiter_if.sv | 14 +
 rtl/axi4s_packet_limiter.sv | 108 ++++++++++
 tb/tb_axi4s_packet_limiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4s_packet_limiter_if.sv
// AXI4-Stream beat bundle shared by the packet limiter's ingress and egress sides.
// terror travels with tlast on the egress side only; the slave view omits it.
interface axi4s_packet_limiter_if #(
   parameter int WIDTH = 64
);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;
   logic             terror;

   modport master (output tdata, tvalid, tlast, terror, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axi4s_packet_limiter.sv
// Ingress packet policer: truncates packets longer than MAX_BEATS with a forced tlast,
// flags runts shorter than MIN_BEATS, and reports both through terror on the last beat.
module axi4s_packet_limiter #(
   parameter int WIDTH     = 64,
   parameter int MAX_BEATS = 256,
   parameter int MIN_BEATS = 1,
   parameter int STAT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   axi4s_packet_limiter_if.slave  i_axis,
   axi4s_packet_limiter_if.master o_axis,
   output logic [STAT_W-1:0]     trunc_count,
   output logic [STAT_W-1:0]     runt_count
);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_BEATS);

   typedef enum logic {ST_PASS, ST_DROP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0]   tdata_q, tdata_d;
   logic               tvalid_q, tvalid_d;
   logic               tlast_q, tlast_d;
   logic               terror_q, terror_d;
   logic [STAT_W-1:0]  trunc_q, trunc_d;
   logic [STAT_W-1:0]  runt_q, runt_d;
   logic               in_ready, accept, force_last, is_runt;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      cnt_inc    = cnt_q + 1'b1;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      terror_d   = terror_q;
      trunc_d    = trunc_q;
      runt_d     = runt_q;
      force_last = 1'b0;
      is_runt    = 1'b0;

      if (!rst_n || clear)         in_ready = 1'b0;
      else if (state_q == ST_DROP) in_ready = 1'b1;
      else                         in_ready = !tvalid_q || o_axis.tready;
      accept = in_ready && i_axis.tvalid;

      if (tvalid_q && o_axis.tready) tvalid_d = 1'b0;

      if (clear) begin
         tvalid_d = 1'b0;
         state_d  = ST_PASS;
         cnt_d    = '0;
      end else if (accept) begin
         if (state_q == ST_DROP) begin
            // Remainder of a truncated packet: consumed without touching the output stage.
            cnt_d = '0;
            if (i_axis.tlast) state_d = ST_PASS;
         end else begin
            force_last = (cnt_inc == MAX_C) && !i_axis.tlast;
            is_runt    = i_axis.tlast && (cnt_inc < MIN_C);
            tvalid_d   = 1'b1;
            tdata_d    = i_axis.tdata;
            tlast_d    = i_axis.tlast || force_last;
            terror_d   = force_last || is_runt;
            cnt_d      = (i_axis.tlast || force_last) ? '0 : cnt_inc;
            if (force_last) state_d = ST_DROP;
            if (force_last && !(&trunc_q)) trunc_d = trunc_q + 1'b1;
            if (is_runt && !(&runt_q))     runt_d  = runt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is tested inside the clocked block, making it synchronous; state uses <= only.
      if (!rst_n) begin
         state_q  <= ST_PASS;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         terror_q <= 1'b0;
         trunc_q  <= '0;
         runt_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         terror_q <= terror_d;
         trunc_q  <= trunc_d;
         runt_q   <= runt_d;
      end
   end

   assign i_axis.tready = in_ready;
   assign o_axis.tdata  = tdata_q;
   assign o_axis.tvalid = tvalid_q;
   assign o_axis.tlast  = tlast_q;
   assign o_axis.terror = terror_q;
   assign trunc_count   = trunc_q;
   assign runt_count    = runt_q;
endmodule

// File: tb/tb_axi4s_packet_limiter.sv
// Bench for axi4s_packet_limiter: two instances (MAX 4 / STAT_W 2, and MAX 8 / MIN 3) share
// one driver and one scoreboard monitor, selected by sel; expectations come from a packet-level model.
module tb_axi4s_packet_limiter;
   localparam int W     = 32;
   localparam int MAX_A = 4;
   localparam int MIN_A = 1;
   localparam int SW_A  = 2;
   localparam int MAX_B = 8;
   localparam int MIN_B = 3;
   localparam int SW_B  = 16;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
      logic         err;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic sel = 1'b0;
   logic tv = 1'b0;
   logic tl = 1'b0;
   logic [W-1:0] td = '0;
   logic ordy = 1'b0;
   logic ordy_level = 1'b0;
   logic ordy_rand = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_acc = 0;
   int first_acc = 0;
   int last_xfer = 0;
   int n_long = 0;
   int exp_trunc [2];
   int exp_runt [2];
   beat_t exp_q [$];
   logic [W-1:0] pkt [$];

   logic [SW_A-1:0] trunc_a, runt_a;
   logic [SW_B-1:0] trunc_b, runt_b;

   axi4s_packet_limiter_if #(.WIDTH(W)) in_a ();
   axi4s_packet_limiter_if #(.WIDTH(W)) out_a ();
   axi4s_packet_limiter_if #(.WIDTH(W)) in_b ();
   axi4s_packet_limiter_if #(.WIDTH(W)) out_b ();

   assign in_a.tvalid  = tv && !sel;
   assign in_a.tdata   = td;
   assign in_a.tlast   = tl;
   assign in_a.terror  = 1'b0;
   assign out_a.tready = ordy;
   assign in_b.tvalid  = tv && sel;
   assign in_b.tdata   = td;
   assign in_b.tlast   = tl;
   assign in_b.terror  = 1'b0;
   assign out_b.tready = ordy;

   axi4s_packet_limiter #(.WIDTH(W), .MAX_BEATS(MAX_A), .MIN_BEATS(MIN_A), .STAT_W(SW_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .i_axis(in_a), .o_axis(out_a),
      .trunc_count(trunc_a), .runt_count(runt_a));

   axi4s_packet_limiter #(.WIDTH(W), .MAX_BEATS(MAX_B), .MIN_BEATS(MIN_B), .STAT_W(SW_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .i_axis(in_b), .o_axis(out_b),
      .trunc_count(trunc_b), .runt_count(runt_b));

   logic         cur_ready, m_valid, m_last, m_err;
   logic [W-1:0] m_data;
   assign cur_ready = sel ? in_b.tready  : in_a.tready;
   assign m_valid   = sel ? out_b.tvalid : out_a.tvalid;
   assign m_last    = sel ? out_b.tlast  : out_a.tlast;
   assign m_err     = sel ? out_b.terror : out_a.terror;
   assign m_data    = sel ? out_b.tdata  : out_a.tdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (ordy_rand) ordy = 1'($urandom_range(0, 1));
      else           ordy = ordy_level;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every output transfer pops one expected beat.
   initial begin : monitor
      bit    stalled;
      beat_t held;
      beat_t e;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && stalled && m_valid) begin
            check("stall_data", m_data, held.data);
            check("stall_last", m_last, held.last);
            check("stall_err", m_err, held.err);
         end
         if (rst_n && m_valid && ordy) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat: got data %0h with no beat expected", m_data);
            end else begin
               checks--;
               e = exp_q.pop_front();
               check("out_data", m_data, e.data);
               check("out_last", m_last, e.last);
               check("out_err", m_err, e.err);
               last_xfer = cyc + 1;
            end
         end
         stalled = rst_n && m_valid && !ordy;
         held = beat_t'{data: m_data, last: m_last, err: m_err};
      end
   end

   task automatic set_ordy(input logic v);
      ordy_level = v;
      ordy = v;
   endtask

   // Reference model: packet length in, expected output beats and counter deltas out.
   task automatic expect_packet();
      int len  = pkt.size();
      int mx   = sel ? MAX_B : MAX_A;
      int mn   = sel ? MIN_B : MIN_A;
      int cap  = sel ? (1 << SW_B) - 1 : (1 << SW_A) - 1;
      int emit = (len > mx) ? mx : len;
      bit bad  = (len > mx) || (len < mn);
      for (int i = 0; i < emit; i++)
         exp_q.push_back(beat_t'{data: pkt[i], last: (i == emit - 1), err: (i == emit - 1) && bad});
      if (len > mx) begin
         if (exp_trunc[sel] < cap) exp_trunc[sel]++;
      end else if (len < mn) begin
         if (exp_runt[sel] < cap) exp_runt[sel]++;
      end
   endtask

   task automatic drive_beat(input logic [W-1:0] d, input logic last, output int waits);
      bit hs = 1'b0;
      waits = 0;
      tv = 1'b1;
      td = d;
      tl = last;
      while (!hs && waits < 100) begin
         @(negedge clk);
         hs = cur_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      tv = 1'b0;
      tl = 1'b0;
      check("in_handshake", hs, 1'b1);
      last_acc = cyc;
   endtask

   task automatic send_packet(input bit gaps);
      int w;
      expect_packet();
      for (int i = 0; i < pkt.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         drive_beat(pkt[i], (i == pkt.size() - 1), w);
      end
   endtask

   task automatic make_seq(input logic [W-1:0] base, input int len);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(base + W'(i));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_counters();
      check("trunc_a", trunc_a, exp_trunc[0]);
      check("runt_a", runt_a, exp_runt[0]);
      check("trunc_b", trunc_b, exp_trunc[1]);
      check("runt_b", runt_b, exp_runt[1]);
   endtask

   task automatic check_reset_outputs();
      check("rst_tvalid_a", out_a.tvalid, 1'b0);
      check("rst_tlast_a", out_a.tlast, 1'b0);
      check("rst_terror_a", out_a.terror, 1'b0);
      check("rst_tdata_a", out_a.tdata, '0);
      check("rst_tvalid_b", out_b.tvalid, 1'b0);
      check("rst_tdata_b", out_b.tdata, '0);
      check_counters();
   endtask

   initial begin
      int w;
      int len;
      exp_trunc = '{0, 0};
      exp_runt  = '{0, 0};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tready_a", in_a.tready, 1'b0);
      check("rst_tready_b", in_b.tready, 1'b0);
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back 1, 3, 4 beat packets at full throughput.
      sel = 1'b0;
      set_ordy(1'b1);
      make_seq('h100, 1);
      send_packet(1'b0);
      first_acc = last_acc;
      make_seq('h110, 3);
      send_packet(1'b0);
      make_seq('h120, 4);
      send_packet(1'b0);
      wait_drain();
      check("throughput_span", last_xfer - first_acc, 8);
      check_counters();

      // 7-beat packet truncated at 4; dropped beats accepted with output stalled.
      make_seq('h0, 7);
      expect_packet();
      for (int i = 0; i < 4; i++) drive_beat(pkt[i], 1'b0, w);
      set_ordy(1'b0);
      for (int i = 4; i < 7; i++) begin
         drive_beat(pkt[i], (i == 6), w);
         check("drop_ready_waits", w, 1);
      end
      set_ordy(1'b1);
      pkt.delete();
      pkt.push_back('hA);
      pkt.push_back('hB);
      send_packet(1'b0);
      wait_drain();
      check_counters();

      // Runt detection on the MIN_BEATS=3 instance.
      sel = 1'b1;
      make_seq('h200, 2);
      send_packet(1'b0);
      make_seq('h300, 3);
      send_packet(1'b0);
      wait_drain();
      check_counters();

      // Random packets with random backpressure and input gaps.
      ordy_rand = 1'b1;
      repeat (100) begin
         len = $urandom_range(1, 10);
         if (len > MAX_B) n_long++;
         pkt.delete();
         for (int i = 0; i < len; i++) pkt.push_back($urandom);
         send_packet(1'b1);
      end
      wait_drain();
      ordy_rand = 1'b0;
      set_ordy(1'b1);
      check("trunc_b_long", trunc_b, n_long);
      check_counters();

      // Clear during beat 2 of a 5-beat packet, then a clean 3-beat packet.
      sel = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      make_seq('h500, 5);
      exp_q.push_back(beat_t'{data: pkt[0], last: 1'b0, err: 1'b0});
      drive_beat(pkt[0], 1'b0, w);
      tv = 1'b1;
      td = pkt[1];
      tl = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      check("clear_tready", in_a.tready, 1'b0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      tv = 1'b0;
      @(negedge clk);
      check("clear_tvalid", out_a.tvalid, 1'b0);
      @(posedge clk);
      #1;
      make_seq('h600, 3);
      send_packet(1'b0);
      wait_drain();
      check_counters();

      // Saturation of the 2-bit truncation counter.
      repeat (5) begin
         make_seq('h700, 6);
         send_packet(1'b0);
      end
      wait_drain();
      check("trunc_sat", trunc_a, 3);
      check_counters();

      // Reset mid-packet with a stalled output beat, then fresh packets.
      set_ordy(1'b0);
      make_seq('h800, 3);
      drive_beat(pkt[0], 1'b0, w);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_tready_a", in_a.tready, 1'b0);
      check("midrst_tready_b", in_b.tready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_trunc = '{0, 0};
      exp_runt  = '{0, 0};
      check_reset_outputs();
      set_ordy(1'b1);
      make_seq('h900, 4);
      send_packet(1'b0);
      make_seq('hA00, 5);
      send_packet(1'b0);
      wait_drain();
      check_counters();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
